// File: rtl/crossbar_pkg.sv
// Shared constants and types for the 4-master x 4-slave crossbar.
// Each slave owns one quarter of the address map, selected by the top two address bits.
package crossbar_pkg;

    localparam int XBAR_ADDR_WIDTH  = 32;
    localparam int XBAR_DATA_WIDTH  = 32;
    localparam int XBAR_NUM_MASTERS = 4;

    localparam logic [31:0] SLAVE_0_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] SLAVE_1_BASE_ADDR = 32'h4000_0000;
    localparam logic [31:0] SLAVE_2_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] SLAVE_3_BASE_ADDR = 32'hC000_0000;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Slave-select field occupies the top SEL_BITS bits of an address.
    localparam int SEL_BITS = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/slave_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester strictly after rr_ptr.
// Returns the winner both one-hot and as an index, plus a flag when anyone requested.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          found
);

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(rr_ptr) + k) % N;
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave arbitration engine: picks an eligible master round-robin, runs one
// slave handshake on latched command values, and returns ack/rdata or a timeout error.
module slave_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int ADDR_WIDTH     = XBAR_ADDR_WIDTH,
    parameter int DATA_WIDTH     = XBAR_DATA_WIDTH,
    parameter int NUM_MASTERS    = XBAR_NUM_MASTERS,
    parameter int SLAVE_ID       = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              areset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]            m_cmd,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic                              s_req,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic                              s_cmd,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              busy
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SEL_BITS-1:0] SEL_MATCH = SEL_BITS'(SLAVE_ID);
    localparam logic [CW-1:0] TC_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr;
    logic [CW-1:0]        tcount;
    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] pick;
    logic [IW-1:0]        pick_idx;
    logic                 found;
    logic                 timeout_hit;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = m_req[i] &&
                      (m_addr[i*ADDR_WIDTH + ADDR_WIDTH - SEL_BITS +: SEL_BITS] == SEL_MATCH);
        end
    end

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req      (elig),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (found)
    );

    assign timeout_hit = TIMEOUT_EN && (tcount == TC_LAST);

    // rr_ptr doubles as the owner index for the whole transaction.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            rr_ptr  <= IW'(NUM_MASTERS - 1);
            tcount  <= '0;
            s_req   <= 1'b0;
            s_addr  <= '0;
            s_cmd   <= 1'b0;
            s_wdata <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        rr_ptr  <= pick_idx;
                        grant   <= pick;
                        s_req   <= 1'b1;
                        s_addr  <= m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        s_cmd   <= m_cmd[pick_idx];
                        s_wdata <= m_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        busy    <= 1'b1;
                        tcount  <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    tcount <= tcount + CW'(1);
                    if (s_ack) begin
                        s_req                                  <= 1'b0;
                        m_ack[rr_ptr]                          <= 1'b1;
                        m_rdata[rr_ptr*DATA_WIDTH +: DATA_WIDTH] <= s_rdata;
                        state                                  <= COOLDOWN;
                    end else if (timeout_hit) begin
                        s_req                                  <= 1'b0;
                        m_ack[rr_ptr]                          <= 1'b1;
                        m_err[rr_ptr]                          <= 1'b1;
                        m_rdata[rr_ptr*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        state                                  <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    m_ack  <= '0;
                    m_err  <= '0;
                    grant  <= '0;
                    tcount <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed scoreboard bench for slave_port_arbiter with a small RAM slave model.
// Stimulus pushes expected acks; a negedge monitor pops and checks each m_ack pulse.
module tb_slave_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NM = 4;

    logic            clk = 1'b0;
    logic            areset = 1'b0;
    logic [NM-1:0]   m_req = '0;
    logic [NM*AW-1:0] m_addr = '0;
    logic [NM-1:0]   m_cmd = '0;
    logic [NM*DW-1:0] m_wdata = '0;
    logic [NM-1:0]   m_ack;
    logic [NM-1:0]   m_err;
    logic [NM*DW-1:0] m_rdata;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_cmd;
    logic [DW-1:0]   s_wdata;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;
    logic [NM-1:0]   grant;
    logic            busy;

    slave_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM),
        .SLAVE_ID(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .areset(areset),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave RAM model: acks one cycle after s_req rises, unless ack_enable is low.
    logic        ack_enable = 1'b1;
    logic [31:0] mem [0:15];
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            s_ack   <= 1'b0;
            s_rdata <= '0;
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[1] <= 32'hAA00_0004;
        end else begin
            s_ack <= 1'b0;
            if (s_req && !s_ack && ack_enable) begin
                s_ack   <= 1'b1;
                s_rdata <= mem[s_addr[5:2]];
                if (s_cmd) mem[s_addr[5:2]] <= s_wdata;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        check_data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          ack_cycle [NM];
    int          sreq_run = 0;
    int          sreq_len = 0;
    logic [NM-1:0] prev_ack = '0;
    logic        err_seen = 1'b0;

    always @(posedge clk) cycle++;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            compare("unexpected_ack", 32'(m_ack), 32'h0);
        end else begin
            e = exp_q.pop_front();
            compare("ack_master", 32'(m_ack), 32'(4'b0001 << e.idx));
            compare("ack_err", 32'(m_err), e.err ? 32'(4'b0001 << e.idx) : 32'h0);
            compare("ack_grant", 32'(grant), 32'(4'b0001 << e.idx));
            compare("ack_single_pulse", 32'(prev_ack), 32'h0);
            if (e.check_data) compare("ack_rdata", m_rdata[e.idx*DW +: DW], e.rdata);
            ack_cycle[e.idx] = cycle;
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (areset) begin
            sreq_run = 0;
            prev_ack = '0;
        end else begin
            if (s_req) sreq_run++;
            else if (sreq_run != 0) begin
                sreq_len = sreq_run;
                sreq_run = 0;
            end
            if (m_err != '0) err_seen = 1'b1;
            if (m_ack != '0) checkOutput();
            prev_ack = m_ack;
        end
    end

    task automatic applyStimulus(input int i, input logic [31:0] addr, input logic cmd,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic check_data, input logic err, input logic expect_ack);
        exp_t e;
        m_addr[i*AW +: AW]  = addr;
        m_cmd[i]            = cmd;
        m_wdata[i*DW +: DW] = wdata;
        m_req[i]            = 1'b1;
        if (expect_ack) begin
            e.idx = i; e.rdata = rdata; e.check_data = check_data; e.err = err;
            exp_q.push_back(e);
        end
    endtask

    // Each master drops its request once it sees its own ack.
    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < NM; i++) if (m_ack[i]) m_req[i] = 1'b0;
    endtask

    task automatic waitAck(input int i, input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_ack[i] && n < limit);
        if (!m_ack[i]) expired($sformatf("wait_ack_m%0d", i));
    endtask

    task automatic waitSreq(input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_req && n < limit);
        if (!s_req) expired("wait_s_req");
    endtask

    initial begin
        logic activity;
        #1 areset = 1'b1;
        #1;
        compare("reset_grant", 32'(grant), 32'h0);
        compare("reset_s_req", 32'(s_req), 32'h0);
        compare("reset_busy", 32'(busy), 32'h0);
        compare("reset_m_ack", 32'(m_ack), 32'h0);
        step();
        step();
        areset = 1'b0;
        step();

        // All four masters read the same slave-0 word.
        err_seen = 1'b0;
        for (int i = 0; i < NM; i++)
            applyStimulus(i, 32'h0000_0004, 1'b0, 32'h0, 32'hAA00_0004, 1'b1, 1'b0, 1'b1);
        waitAck(3, 60);
        compare("rr_spacing_0_1", 32'(ack_cycle[1] - ack_cycle[0]), 32'd4);
        compare("rr_spacing_1_2", 32'(ack_cycle[2] - ack_cycle[1]), 32'd4);
        compare("rr_spacing_2_3", 32'(ack_cycle[3] - ack_cycle[2]), 32'd4);
        compare("no_err_during_reads", 32'(err_seen), 32'h0);

        // Master 2 write then readback.
        applyStimulus(2, 32'h0000_0008, 1'b1, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 1'b1);
        waitSreq(20);
        compare("write_s_cmd", 32'(s_cmd), 32'h1);
        compare("write_s_wdata", s_wdata, 32'h1122_3344);
        compare("write_s_addr", s_addr, 32'h0000_0008);
        waitAck(2, 20);
        applyStimulus(2, 32'h0000_0008, 1'b0, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 1'b1);
        waitAck(2, 20);
        step();

        // Master 1 targets slave 1; this instance must ignore it.
        applyStimulus(1, 32'h4000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        activity = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (grant != '0 || s_req) activity = 1'b1;
        end
        compare("foreign_addr_no_grant", 32'(activity), 32'h0);
        m_req[1] = 1'b0;
        step();

        // Hung slave: master 0 times out, master 1 goes next.
        ack_enable = 1'b0;
        applyStimulus(0, 32'h0000_0004, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1, 32'h0000_0004, 1'b0, 32'h0, 32'hAA00_0004, 1'b1, 1'b0, 1'b1);
        waitAck(0, 40);
        ack_enable = 1'b1;
        compare("timeout_s_req_cycles", 32'(sreq_len), 32'd16);
        waitAck(1, 20);
        step();

        // Reset while master 3 is mid-transaction.
        applyStimulus(3, 32'h0000_0004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        waitSreq(20);
        compare("pre_reset_grant", 32'(grant), 32'h8);
        #2 areset = 1'b1;
        #1;
        compare("async_reset_s_req", 32'(s_req), 32'h0);
        compare("async_reset_grant", 32'(grant), 32'h0);
        compare("async_reset_busy", 32'(busy), 32'h0);
        compare("async_reset_m_ack", 32'(m_ack), 32'h0);
        compare("async_reset_m_err", 32'(m_err), 32'h0);
        compare("async_reset_rdata", 32'(|m_rdata), 32'h0);
        m_req[3] = 1'b0;
        step();
        areset = 1'b0;
        step();

        // Master 0 wins first after reset, then re-requests behind 1 and 2.
        applyStimulus(0, 32'h0000_0004, 1'b0, 32'h0, 32'hAA00_0004, 1'b1, 1'b0, 1'b1);
        applyStimulus(1, 32'h0000_0004, 1'b0, 32'h0, 32'hAA00_0004, 1'b1, 1'b0, 1'b1);
        applyStimulus(2, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        waitAck(0, 20);
        applyStimulus(0, 32'h0000_0004, 1'b0, 32'h0, 32'hAA00_0004, 1'b1, 1'b0, 1'b1);
        waitAck(1, 20);
        waitAck(2, 20);
        waitAck(0, 20);

        for (int n = 0; n < 6; n++) step();
        compare("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
